// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the width helper used to size the bit counter.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
// Purely combinational; the serial subtractor iterates it in time.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor D = A - B over WIDTH clock cycles.
// start is accepted in IDLE or DONE; busy is high while running; done pulses
// for one cycle when D/Bout/V are updated. D/Bout/V hold until the next result.
// Optional feature: define SERIAL_SUB_OVF_EN to build signed-overflow output V;
// otherwise V is tied low and no operand-MSB capture registers exist.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             borrow;
    // a_sh doubles as the result register: each difference bit enters at the
    // MSB while the minuend drains out of the LSB, so after WIDTH shifts it
    // holds the LSB-aligned difference.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             accept;
    logic             last;
    logic             d_bit;
    logic             br_next;

    full_subtractor u_cell (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .bin (borrow),
        .d   (d_bit),
        .bout(br_next)
    );

    assign accept = (state != RUN) && start;
    assign last   = (cnt == LAST);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // Next-state logic: IDLE/DONE accept start, RUN ends on the last bit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Operand shift registers: load on accepted start, shift each RUN cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= A;
            b_sh <= B;
        end else if (state == RUN) begin
            a_sh <= {d_bit, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
        end
    end

    // Bit counter and borrow flip-flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            borrow <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            borrow <= 1'b0;
        end else if (state == RUN) begin
            cnt    <= cnt + CNT_W'(1);
            borrow <= br_next;
        end
    end

    // Result commit on the last processing edge, including the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            D    <= '0;
            Bout <= 1'b0;
        end else if ((state == RUN) && last) begin
            D    <= {d_bit, a_sh[WIDTH-1:1]};
            Bout <= br_next;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;

    // Capture operand sign bits at the accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
        end
    end

    // Signed overflow: operand signs differ and the result sign differs from A.
    always_ff @(posedge clk) begin
        if (rst)                         V <= 1'b0;
        else if ((state == RUN) && last) V <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
    end
`else
    assign V = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a WIDTH=8 and a WIDTH=4 instance,
// each checked every cycle against a transaction-level model, plus literal
// expectations for the directed cases. Honors SERIAL_SUB_OVF_EN for V.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8, done8, bout8, v8;
    logic [7:0] d8;
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4, done4, bout4, v4;
    logic [3:0] d4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .D(d8), .Bout(bout8), .V(v8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .D(d4), .Bout(bout4), .V(v4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Transaction model: rem counts processing cycles left in a run; results
    // become visible (with a done pulse) when it reaches zero.
    int rem[2];
    int pd[2], ed[2];
    bit pb[2], pv[2], eb[2], ev[2], edone[2];

    task automatic model_step(input int k, input int w, input bit r, input bit s,
                              input int a, input int b);
        int sa, sb, diff;
        if (r) begin
            rem[k] = 0; edone[k] = 0; ed[k] = 0; eb[k] = 0; ev[k] = 0;
        end else if (rem[k] > 0) begin
            rem[k] = rem[k] - 1;
            edone[k] = (rem[k] == 0);
            if (rem[k] == 0) begin
                ed[k] = pd[k]; eb[k] = pb[k]; ev[k] = pv[k];
            end
        end else begin
            edone[k] = 0;
            if (s) begin
                rem[k] = w;
                pd[k] = (a - b) & ((1 << w) - 1);
                pb[k] = (a < b);
                sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
                sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
                diff = sa - sb;
`ifdef SERIAL_SUB_OVF_EN
                pv[k] = (diff > (1 << (w - 1)) - 1) || (diff < -(1 << (w - 1)));
`else
                pv[k] = 0;
`endif
            end
        end
    endtask

    // Compare process: advance the model on every edge, check all outputs.
    always @(posedge clk) begin
        model_step(0, 8, rst, start8, int'(a8), int'(b8));
        model_step(1, 4, rst, start4, int'(a4), int'(b4));
        #1;
        chk("busy8", busy8, rem[0] > 0);
        chk("done8", done8, edone[0]);
        chk("d8",    d8,    ed[0]);
        chk("bout8", bout8, eb[0]);
        chk("v8",    v8,    ev[0]);
        chk("busy4", busy4, rem[1] > 0);
        chk("done4", done4, edone[1]);
        chk("d4",    d4,    ed[1]);
        chk("bout4", bout4, eb[1]);
        chk("v4",    v4,    ev[1]);
    end

    // Single operation on the 8-bit instance; reports start-to-done edges
    // (counting the accepting edge) and busy cycles.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       output int edges, output int busy_cnt);
        bit seen;
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        edges = 1; busy_cnt = 0; seen = 0;
        if (busy8) busy_cnt++;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            edges++;
            #1;
            if (done8) seen = 1;
            else if (busy8) busy_cnt++;
        end
        if (!seen) chk("op8_timeout", 32'd0, 32'd1);
    endtask

    initial begin : stim
        int edges, bc;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy8, 1'b0);
        chk("reset_done", done8, 1'b0);
        chk("reset_d",    d8,    8'h00);
        rst = 1'b0;

        // Directed: 5 - 3 and 3 - 5.
        op8(8'h05, 8'h03, edges, bc);
        chk("lat_5m3",  edges, 9);
        chk("busy_5m3", bc,    8);
        chk("d_5m3",    d8,    8'h02);
        chk("b_5m3",    bout8, 1'b0);
        chk("v_5m3",    v8,    1'b0);
        op8(8'h03, 8'h05, edges, bc);
        chk("d_3m5",    d8,    8'hFE);
        chk("b_3m5",    bout8, 1'b1);
`ifdef SERIAL_SUB_OVF_EN
        op8(8'h80, 8'h01, edges, bc);
        chk("d_80m01",  d8, 8'h7F);
        chk("v_80m01",  v8, 1'b1);
        op8(8'h7F, 8'hFF, edges, bc);
        chk("d_7Fm",    d8, 8'h80);
        chk("v_7Fm",    v8, 1'b1);
`endif

        // Back-to-back with start held high; operand noise during RUN.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
        repeat (8) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom);
        end
        @(negedge clk);
        chk("b2b_done1", done8, 1'b1);
        chk("b2b_d1",    d8,    8'h0F);
        chk("b2b_b1",    bout8, 1'b0);
        a8 = 8'h00; b8 = 8'h01;
        repeat (8) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom);
        end
        @(negedge clk);
        chk("b2b_done2", done8, 1'b1);
        chk("b2b_d2",    d8,    8'hFF);
        chk("b2b_b2",    bout8, 1'b1);
        start8 = 1'b0;

        // Reset in the middle of a run (edge processing bit 4).
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h22; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy8, 1'b0);
        chk("midrst_done", done8, 1'b0);
        chk("midrst_d",    d8,    8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        op8(8'hC8, 8'h37, edges, bc);
        chk("after_rst_d", d8, 8'h91);

        // Reset and start at the same edge.
        @(negedge clk);
        rst = 1'b1; start8 = 1'b1; a8 = 8'h09; b8 = 8'h01;
        @(posedge clk);
        #1;
        chk("rst_start_busy", busy8, 1'b0);
        chk("rst_start_d",    d8,    8'h00);
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0;

        // Exhaustive 4-bit sweep, back-to-back, with noise during RUN.
        for (int p = 0; p < 256; p++) begin
            @(negedge clk);
            a4 = 4'(p >> 4); b4 = 4'(p); start4 = 1'b1;
            repeat (4) begin
                @(negedge clk);
                a4 = 4'($urandom); b4 = 4'($urandom); start4 = 1'($urandom);
            end
        end
        @(negedge clk);
        start4 = 1'b0;

        // Randomised 8-bit operations with random gaps and start noise.
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'($urandom);
        end
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
